// File: rtl/exp2_fp32.sv
// exp2_fp32: three-stage pipelined FP32 base-2 exponential, y -> 2^y.
// S1 captures the operand, S2 classifies it and converts it to a signed
// Q8.23 fixed-point value (integer part I, fraction F), and S3 forms 2^F
// with a shift-add corrected quadratic and packs I into the exponent field.
module exp2_fp32 #(
  parameter int DATA_WIDTH = 32,
  parameter int EXPO_WIDTH = 8,
  parameter int MANT_WIDTH = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  vld_in,
  input  logic [DATA_WIDTH-1:0] Oprand_A_D,
  output logic [DATA_WIDTH-1:0] Result_out,
  output logic                  vld_out,
  output logic                  busy
);

  localparam int EW        = EXPO_WIDTH + 2;          // signed exponent arithmetic width
  localparam int INT_WIDTH = DATA_WIDTH - MANT_WIDTH; // signed integer part of Z

  typedef logic signed [EW-1:0] sexp_t;

  localparam sexp_t BIAS  = sexp_t'((1 << (EXPO_WIDTH - 1)) - 1);
  // Largest e whose magnitude still fits the Q8.23 integer field.
  localparam sexp_t E_MAX = sexp_t'(INT_WIDTH - 2);
  // Below this, {1,M} shifts out entirely and 2^y rounds to 1.0.
  localparam sexp_t E_MIN = sexp_t'(-(MANT_WIDTH + 1));

  localparam logic [DATA_WIDTH-1:0] QNAN_VAL =
    {1'b0, {EXPO_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] INF_VAL =
    {1'b0, {EXPO_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ONE_VAL =
    {2'b00, {(EXPO_WIDTH-1){1'b1}}, {MANT_WIDTH{1'b0}}};

  // ---------------------------------------------------------------- S1
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_vld;

  // S1: capture the raw operand and its valid.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every stage reads the previous cycle's values
    // no matter in which order the simulator evaluates these blocks.
    if (rst) begin
      s1_data <= '0;
      s1_vld  <= 1'b0;
    end else if (en) begin
      s1_data <= Oprand_A_D;
      s1_vld  <= vld_in;
    end
  end

  // ---------------------------------------------------------------- S2
  logic                  sign_c;
  logic [EXPO_WIDTH-1:0] expo_c;
  logic [MANT_WIDTH-1:0] mant_c;
  sexp_t                 e_c;
  sexp_t                 neg_e_c;
  logic [DATA_WIDTH-2:0] x_base_c;
  logic [DATA_WIDTH-2:0] x_c;
  logic [DATA_WIDTH-1:0] z_c;
  logic                  spec_c;
  logic [DATA_WIDTH-1:0] spec_val_c;

  // S2 combinational: classify the operand and convert it to signed Q8.23.
  always_comb begin
    // NOTE: every output gets a default first so no branch leaves one
    // unassigned, which would otherwise infer a latch.
    spec_c     = 1'b0;
    spec_val_c = '0;
    sign_c     = s1_data[DATA_WIDTH-1];
    expo_c     = s1_data[DATA_WIDTH-2 -: EXPO_WIDTH];
    mant_c     = s1_data[MANT_WIDTH-1:0];
    e_c        = $signed({2'b00, expo_c}) - BIAS;
    neg_e_c    = -e_c;
    x_base_c   = {{(DATA_WIDTH-MANT_WIDTH-2){1'b0}}, 1'b1, mant_c};

    if (e_c[EW-1] == 1'b0) x_c = x_base_c << e_c;
    else                   x_c = x_base_c >> neg_e_c;

    // Negative inputs become two's complement so Z[31:23] is floor(y).
    if (sign_c) z_c = -{1'b0, x_c};
    else        z_c =  {1'b0, x_c};

    if (expo_c == '1 && mant_c != '0) begin
      spec_c     = 1'b1;
      spec_val_c = QNAN_VAL;
    end else if (e_c >= E_MAX) begin
      spec_c     = 1'b1;
      spec_val_c = sign_c ? '0 : INF_VAL;
    end else if (expo_c == '0 || e_c < E_MIN) begin
      spec_c     = 1'b1;
      spec_val_c = ONE_VAL;
    end
  end

  logic                  s2_special;
  logic [DATA_WIDTH-1:0] s2_spec_val;
  logic [INT_WIDTH-1:0]  s2_int;
  logic [MANT_WIDTH-1:0] s2_frac;
  logic                  s2_vld;

  // S2 register: special flag/value plus integer and fraction of y.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_special  <= 1'b0;
      s2_spec_val <= '0;
      s2_int      <= '0;
      s2_frac     <= '0;
      s2_vld      <= 1'b0;
    end else if (en) begin
      s2_special  <= spec_c;
      s2_spec_val <= spec_val_c;
      s2_int      <= z_c[DATA_WIDTH-1:MANT_WIDTH];
      s2_frac     <= z_c[MANT_WIDTH-1:0];
      s2_vld      <= s1_vld;
    end
  end

  // ---------------------------------------------------------------- S3
  logic [MANT_WIDTH:0]     frac_comp_c;
  logic [2*MANT_WIDTH:0]   prod_c;
  logic [MANT_WIDTH-1:0]   p_c;
  logic [MANT_WIDTH-1:0]   corr_c;
  logic [MANT_WIDTH-1:0]   mant_out_c;
  sexp_t                   ex_c;
  logic [DATA_WIDTH-1:0]   result_c;

  // S3 combinational: 2^F ~= 1 + F - 0.34375*F*(1-F), then pack with I+bias.
  always_comb begin
    frac_comp_c = {1'b1, {MANT_WIDTH{1'b0}}} - {1'b0, s2_frac};
    prod_c      = {{(MANT_WIDTH+1){1'b0}}, s2_frac} * {{MANT_WIDTH{1'b0}}, frac_comp_c};
    p_c         = MANT_WIDTH'(prod_c >> MANT_WIDTH);
    corr_c      = (p_c >> 2) + (p_c >> 4) + (p_c >> 5);
    // F*(1-F) <= 1/4, so corr stays well below F and cannot underflow.
    mant_out_c  = s2_frac - corr_c;
    ex_c        = $signed({s2_int[INT_WIDTH-1], s2_int}) + BIAS;

    if (s2_special)                     result_c = s2_spec_val;
    else if (ex_c[EW-1] || ex_c == '0)  result_c = '0;
    else                                result_c = {1'b0, ex_c[EXPO_WIDTH-1:0], mant_out_c};
  end

  // S3 register: packed result and its valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      Result_out <= '0;
      vld_out    <= 1'b0;
    end else if (en) begin
      Result_out <= result_c;
      vld_out    <= s2_vld;
    end
  end

  // Pipeline occupancy for upstream/downstream drain control.
  always_comb begin
    busy = s1_vld | s2_vld | vld_out;
  end

endmodule
